// File: rtl/cooktime_count.sv
// Egg-timer cook-time setter: synchronize + debounce the button, add one minute per press (BCD 00-99).
// Define COOKTIME_AUTOREPEAT_EN to add hold-to-repeat increments.
module cooktime_count #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int MAX_TENS        = 9,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_RATE     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       main_enable,
  input  logic       button_in,
  output logic [3:0] ones,
  output logic [3:0] tens
);

  localparam logic [3:0] DB_LIM = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0] MT     = 4'(MAX_TENS);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15 || MAX_TENS < 1 || MAX_TENS > 9 ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > 255 || REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_bad_cfg
    $error("cooktime_count: parameter out of legal range");
  end

  logic       sync1_q, sync2_q, deb_q, edge_q;
  logic [3:0] dcnt_q, dcnt_inc;
  logic       press, inc;
  logic [3:0] ones_q, ones_d, tens_q, tens_d;

  assign dcnt_inc = dcnt_q + 4'd1;
  // edge_q holds last cycle's debounced level, so press is high for exactly one cycle per rise
  assign press    = deb_q & ~edge_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      dcnt_q  <= 4'd0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= button_in;
      sync2_q <= sync1_q;
      edge_q  <= deb_q;
      if (sync2_q == deb_q) begin
        dcnt_q <= 4'd0;
      end else if (dcnt_inc == DB_LIM) begin
        deb_q  <= sync2_q;
        dcnt_q <= 4'd0;
      end else begin
        dcnt_q <= dcnt_inc;
      end
    end
  end

`ifdef COOKTIME_AUTOREPEAT_EN
  localparam logic [7:0] RPT_DLY  = 8'(REPEAT_DELAY);
  localparam logic [7:0] RPT_RATE = 8'(REPEAT_RATE);

  logic [7:0] rpt_q;
  logic       rpt_arm_q, rpt_fast_q, rpt_fire;

  // Armed only by an accepted press, so re-enabling during a hold never starts repeats
  assign rpt_fire = rpt_arm_q & deb_q & main_enable &
                    ((rpt_q + 8'd1) == (rpt_fast_q ? RPT_RATE : RPT_DLY));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_q      <= 8'd0;
      rpt_arm_q  <= 1'b0;
      rpt_fast_q <= 1'b0;
    end else if (!deb_q || !main_enable) begin
      rpt_q      <= 8'd0;
      rpt_arm_q  <= 1'b0;
      rpt_fast_q <= 1'b0;
    end else if (press) begin
      rpt_q      <= 8'd0;
      rpt_arm_q  <= 1'b1;
      rpt_fast_q <= 1'b0;
    end else if (rpt_arm_q) begin
      if (rpt_fire) begin
        rpt_q      <= 8'd0;
        rpt_fast_q <= 1'b1;
      end else begin
        rpt_q <= rpt_q + 8'd1;
      end
    end
  end

  assign inc = (press & main_enable) | rpt_fire;
`else
  assign inc = press & main_enable;
`endif

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (inc) begin
      if (ones_q < 4'd9) begin
        ones_d = ones_q + 4'd1;
      end else begin
        ones_d = 4'd0;
        tens_d = (tens_q >= MT) ? 4'd0 : tens_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;

endmodule

// File: tb/tb_cooktime_count.sv
// Directed bench for cooktime_count (default build): latency, glitch, carry/wrap, enable gating, async reset.
module tb_cooktime_count;

  logic       clk = 1'b0;
  logic       reset;
  logic       main_enable;
  logic       button_in;
  logic [3:0] ones, tens;

  int nvec = 0;
  int nerr = 0;

  cooktime_count dut (
    .clk        (clk),
    .reset      (reset),
    .main_enable(main_enable),
    .button_in  (button_in),
    .ones       (ones),
    .tens       (tens)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hi);
    button_in = 1'b1;
    cyc(hi);
    button_in = 1'b0;
    cyc(7);
  endtask

  initial begin
    reset       = 1'b0;
    main_enable = 1'b1;
    button_in   = 1'b0;

    // Reset held while the button toggles
    for (int i = 0; i < 6; i++) begin
      button_in = i[0];
      @(negedge clk);
      chk("reset_hold", {tens, ones}, 8'h00);
    end
    button_in = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(5);
    chk("reset_idle", {tens, ones}, 8'h00);

    // Single press: change lands exactly at E4
    button_in = 1'b1;
    cyc(1);                                     // E0 passed
    cyc(3);                                     // E1..E3
    chk("lat_E3", {tens, ones}, 8'h00);
    cyc(1);                                     // E4
    chk("lat_E4", {tens, ones}, 8'h01);
    button_in = 1'b0;
    cyc(7);
    chk("release", {tens, ones}, 8'h01);

    // Glitch rejection, then minimum qualifying press
    press(1);
    chk("glitch1", {tens, ones}, 8'h01);
    press(2);
    chk("press2", {tens, ones}, 8'h02);

    // Carry and wrap from 00
    @(posedge clk); #2 reset = 1'b0; #2 reset = 1'b1;
    cyc(2);
    chk("clr", {tens, ones}, 8'h00);
    for (int n = 1; n <= 120; n++) begin
      press(4);
      if (n == 9)   chk("p9",   {tens, ones}, 8'h09);
      if (n == 10)  chk("p10",  {tens, ones}, 8'h10);
      if (n == 99)  chk("p99",  {tens, ones}, 8'h99);
      if (n == 100) chk("p100", {tens, ones}, 8'h00);
      if (n == 120) chk("p120", {tens, ones}, 8'h20);
    end

    // Enable gating
    main_enable = 1'b0;
    for (int n = 0; n < 5; n++) press(4);
    chk("en_off", {tens, ones}, 8'h20);
    button_in = 1'b1;
    cyc(8);
    main_enable = 1'b1;
    cyc(6);
    button_in = 1'b0;
    cyc(7);
    chk("en_raise_held", {tens, ones}, 8'h20);
    press(4);
    chk("en_next", {tens, ones}, 8'h21);

    // Async reset mid-count at 37
    for (int n = 0; n < 16; n++) press(4);
    chk("at37", {tens, ones}, 8'h37);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("async_clr", {tens, ones}, 8'h00);
    #2 reset = 1'b1;
    cyc(3);
    chk("after_rst", {tens, ones}, 8'h00);

    // Reset during a held press: re-qualifies and counts once
    button_in = 1'b1;
    cyc(2);
    @(posedge clk);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    cyc(12);
    button_in = 1'b0;
    cyc(7);
    chk("rst_held", {tens, ones}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cooktime_count.md
Name: cooktime_count

Overview:
Cook-time setting counter for the egg timer, clocked at the 10 Hz system tick. Each debounced press of the user button adds one minute to a two-digit BCD cook time (00–99). Outputs `ones`/`tens` feed the display and countdown logic. The block sits between the raw push-button pin and the timer/display path.

Parameters:
- DEBOUNCE_CYCLES, 2, consecutive stable synchronized samples required before the debounced level changes (legal 1–15).
- MAX_TENS, 9, highest tens digit; the count wraps after MAX_TENS·10+9 (legal 1–9).
- REPEAT_DELAY, 10, cycles held before the first auto-repeat (used only with the optional feature).
- REPEAT_RATE, 3, cycles between subsequent auto-repeats (used only with the optional feature).

Ports:
- clk, input, 1, system clock (10 Hz tick); all state on the rising edge.
- reset, input, 1, asynchronous, active-low reset (0 = reset).
- main_enable, input, 1, 1 = presses are accepted; 0 = count frozen.
- button_in, input, 1, raw asynchronous push-button level, active-high.
- ones, output, 4, BCD minutes units digit, 0–9.
- tens, output, 4, BCD minutes tens digit, 0–MAX_TENS.

Behaviour:
- One clock domain. Reset is asynchronous, active-low: while reset=0, the following are all 0:
  - ones and tens
  - both synchronizer flops
  - debounced level and debounce counter
  - edge register
  - repeat counter
- Synchronizer: two-flop chain on button_in.
- Debounce:
  - A counter increments while the synchronized level differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles causes no change.
- Press event: a 0→1 transition of the debounced level, registered as a one-cycle increment pulse.
- Increment is applied only if main_enable=1 in the cycle the pulse is present. If main_enable=0, the event is discarded, not queued. The debouncer runs regardless of main_enable.
- Latency: take edge E0 as the first edge sampling button_in=1. ones/tens change at edge E(2+DEBOUNCE_CYCLES), i.e. E4 for defaults.
- Exactly one increment per press, independent of hold length.
- Release: the 1→0 debounced transition produces no action.
- BCD arithmetic:
  - If ones<9: ones+1.
  - If ones=9: ones←0 and tens increments.
  - At tens=MAX_TENS and ones=9: wrap to 00.
  - Outputs never hold non-BCD values.
- main_enable dropping mid-press: the count holds. Re-raising it while the button is still held does not create an increment; a new 0→1 debounced edge is required.
- Reset asserted mid-press: the count clears immediately. After release of reset with the button still held, the debounced level re-qualifies from 0, and one increment occurs after latency if main_enable=1.
- Outputs are registered; no combinational path from inputs.

Optional Feature:
- Macro: COOKTIME_AUTOREPEAT_EN.
- Defined:
  - While the debounced level stays 1 and main_enable=1, a repeat counter runs.
  - After REPEAT_DELAY cycles following the initial press increment, one extra increment occurs, then another every REPEAT_RATE cycles until release.
  - Release or main_enable=0 clears the repeat counter.
  - Wrap rules are identical to a normal press.
- Not defined: no repeat logic is synthesized; exactly one increment per press.

Test Plan:
- Reset: reset=0 with button_in toggling → ones=0, tens=0 throughout; reset=1, no press → stays 00.
- Single press: main_enable=1, button_in high 4 cycles then low 7 cycles → count 00→01 exactly 4 edges after first high sample; no change on release.
- Carry and wrap: 120 presses (each high 4 cycles, low 7 cycles) →
  - after 9 presses: 09
  - after 10 presses: 10
  - after 99 presses: 99
  - after 100 presses: 00
  - after 120 presses: 20
- Glitch rejection: button_in high for 1 cycle only → no increment; high 2+ cycles → exactly one increment.
- Enable gating: main_enable=0 during 5 presses → count unchanged; raise main_enable while the button is held → no increment; next full press → +1.
- Async reset mid-count: at count 37, pulse reset low for less than one clock period between edges → outputs 00 immediately, without waiting for a clock edge.
